// File: rtl/count_down_nbit.sv
`default_nettype none
// ============================================================================
// Module   : count_down_nbit
// Purpose  : Loadable N-bit down-counter / timer with terminal-count pulse and
//            optional auto-reload (periodic tick generator).
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous active-high reset
//            load        - capture load_val into counter and reload register
//            load_val    - start / reload value
//            en          - count enable
//            auto_reload - 0 = one-shot (stop at 0), 1 = reload at terminal
//            count       - current counter value (registered)
//            zero        - combinational, high when count == 0
//            busy        - registered, high while running
//            done        - registered, one-cycle pulse on terminal count
// Revision : 1.0 - initial release
// ============================================================================
module count_down_nbit #(
    parameter int N_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N_BIT-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [N_BIT-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [N_BIT-1:0] c_zero = '0;
    localparam logic [N_BIT-1:0] c_one  = {{(N_BIT-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [N_BIT-1:0] r_count;
    logic [N_BIT-1:0] r_reload;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [N_BIT-1:0] w_count_nxt;
    logic [N_BIT-1:0] w_reload_nxt;
    logic             w_done_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= c_zero;
            r_reload <= c_zero;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic. A load always wins over a terminal event, so a load
    // landing on the terminal edge suppresses done and restarts the count.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = (load_val != c_zero) ? S_RUN : S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (en) begin
                        if (r_count == c_one) begin
                            // Terminal count; auto_reload is sampled only here.
                            w_done_nxt = 1'b1;
                            if (auto_reload) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_count_nxt = c_zero;
                                w_state_nxt = S_IDLE;
                            end
                        end else if (r_count > c_one) begin
                            w_count_nxt = r_count - c_one;
                        end else begin
                            // Unreachable in RUN (count is never 0 there);
                            // park safely rather than wrap to all-ones.
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    // IDLE holds the count regardless of en.
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign zero  = (r_count == c_zero);
    assign busy  = (r_state == S_RUN);
    assign done  = r_done;

endmodule
`default_nettype wire
